viterbi_depuncturer: RTL and testbench

Depunctures the deinterleaved coded bit stream of the 802.11a receiver for the Viterbi decoder. It accepts one coded bit per handshake and re-inserts the bits stolen by the transmitter's puncturer for rates 2/3 and 3/4. It emits mother-code (rate 1/2) pairs {A,B}, each bit carrying an erasure flag. It sits between the deinterleaver and the Viterbi decoder.

---
 rtl/depuncturer_pkg.sv | 49 ++++
 rtl/depunct_out_reg.sv | 32 +++
 rtl/viterbi_depuncturer.sv | 170 +++++++++++++++++
 tb/tb_viterbi_depuncturer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depuncturer_pkg.sv
// Shared definitions for the 802.11a depuncturer: rate encodings, puncture
// period and stolen-slot masks per rate, FSM states and the output pair type.
package depuncturer_pkg;

  localparam logic [1:0] RATE_1_2  = 2'b00;
  localparam logic [1:0] RATE_2_3  = 2'b01;
  localparam logic [1:0] RATE_3_4  = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,   // slot 0, waiting for the first bit of a frame
    ST_RUN,    // walking the puncture pattern
    ST_PAD,    // inserting an erased B after a frame ended on an A slot
    ST_DRAIN   // final pair of the frame held in the output register
  } state_t;

  // Mother-code pair with per-bit erasure flags and end-of-frame marker.
  typedef struct packed {
    logic a;
    logic b;
    logic erase_a;
    logic erase_b;
    logic last;
  } pair_t;

  // The reserved encoding decodes as rate 1/2.
  function automatic logic [1:0] rate_norm(input logic [1:0] rate);
    return (rate == RATE_RSVD) ? RATE_1_2 : rate;
  endfunction

  // Number of slots in one puncture period (A1 B1 A2 B2 A3 B3 order).
  function automatic logic [2:0] period_of(input logic [1:0] rate);
    case (rate)
      RATE_2_3: return 3'd4;
      RATE_3_4: return 3'd6;
      default:  return 3'd2;
    endcase
  endfunction

  // Bit i set means slot i was stolen by the transmitter.
  function automatic logic [5:0] stolen_mask(input logic [1:0] rate);
    case (rate)
      RATE_2_3: return 6'b001000;
      RATE_3_4: return 6'b011000;
      default:  return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/depunct_out_reg.sv
// Single-entry valid/ready output register holding one depunctured pair.
// A new pair may be loaded on the same edge the current one transfers.
module depunct_out_reg
  import depuncturer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  pair_t next_pair,
  input  logic  ready,
  output logic  valid,
  output pair_t pair
);

  // Load wins over transfer so the stream can run back-to-back.
  // NOTE: every storage element here has a reset value, including the data
  // fields, so outputs read as 0 during and straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pair  <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples the pre-edge values regardless of statement order.
      valid <= 1'b1;
      pair  <= next_pair;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/viterbi_depuncturer.sv
// Depuncturer for the 802.11a receiver: takes one coded bit per handshake,
// re-inserts the bits stolen at rates 2/3 and 3/4 as erasures and emits
// rate-1/2 mother-code pairs {A,B} for the Viterbi decoder.
// Optional build macro: DEPUNCTURER_STATS_EN adds the EraseCount port.
module viterbi_depuncturer
  import depuncturer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  Rate,
  input  logic        InValid,
  input  logic        InBit,
  input  logic        InLast,
  output logic        InReady,
  output logic        OutValid,
  output logic        OutA,
  output logic        OutB,
  output logic        EraseA,
  output logic        EraseB,
  output logic        OutLast,
  input  logic        OutReady
`ifdef DEPUNCTURER_STATS_EN
  ,
  output logic [15:0] EraseCount
`endif
);

  state_t     state;
  logic [2:0] slot;        // pattern slot s, 0..period-1
  logic [1:0] rate_q;      // rate latched at frame start
  logic       hold_bit;    // A value waiting for its B partner
  logic       hold_erase;

  logic [5:0] mask;
  logic       slot_b;
  logic       stolen;
  logic       can_load;
  logic       accept;
  logic       step;
  logic       slot_val;
  logic       slot_erase;
  logic       load;
  logic       frame_start;
  pair_t      next_pair;
  pair_t      pair;

  assign mask     = stolen_mask(rate_q);
  assign slot_b   = slot[0];
  assign stolen   = (state == ST_RUN) && mask[slot];
  assign can_load = !OutValid || OutReady;

  // Ready depends only on state, slot, latched rate and the output handshake.
  assign InReady  = !Reset &&
                    ((state == ST_IDLE) ||
                     ((state == ST_RUN) && !stolen && (!slot_b || can_load)));
  assign accept   = InValid && InReady;

  // A stolen slot advances by itself; a stolen B still needs room to load.
  assign step        = (state == ST_RUN) && (stolen ? (!slot_b || can_load) : accept);
  assign slot_val    = stolen ? 1'b0 : InBit;
  assign slot_erase  = stolen;
  assign load        = ((state == ST_RUN) && step && slot_b) ||
                       ((state == ST_PAD) && can_load);
  assign frame_start = (state == ST_IDLE) && accept;

  // Assemble the pair to load: held A plus the current B slot or a pad erasure.
  always_comb begin
    // NOTE: every field gets a value on every pass, so no latch is inferred.
    next_pair         = '0;
    next_pair.a       = hold_bit;
    next_pair.erase_a = hold_erase;
    if (state == ST_PAD) begin
      next_pair.b       = 1'b0;
      next_pair.erase_b = 1'b1;
      next_pair.last    = 1'b1;
    end else begin
      next_pair.b       = slot_val;
      next_pair.erase_b = slot_erase;
      next_pair.last    = accept && InLast;
    end
  end

  // Frame FSM: slot walk, rate latch, A-hold register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      slot       <= 3'd0;
      rate_q     <= RATE_1_2;
      hold_bit   <= 1'b0;
      hold_erase <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rate_q     <= rate_norm(Rate);
            hold_bit   <= InBit;
            hold_erase <= 1'b0;
            slot       <= 3'd1;
            state      <= InLast ? ST_PAD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (step) begin
            if (!slot_b) begin
              hold_bit   <= slot_val;
              hold_erase <= slot_erase;
            end
            if (accept && InLast) begin
              state <= slot_b ? ST_DRAIN : ST_PAD;
              slot  <= slot_b ? 3'd0 : slot + 3'd1;
            end else if (slot + 3'd1 == period_of(rate_q)) begin
              slot <= 3'd0;
            end else begin
              slot <= slot + 3'd1;
            end
          end
        end
        ST_PAD: begin
          if (can_load) begin
            state <= ST_DRAIN;
            slot  <= 3'd0;
          end
        end
        ST_DRAIN: begin
          if (OutValid && OutReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  depunct_out_reg u_out_reg (
    .clk       (Clock),
    .rst       (Reset),
    .load      (load),
    .next_pair (next_pair),
    .ready     (OutReady),
    .valid     (OutValid),
    .pair      (pair)
  );

  assign OutA    = pair.a;
  assign OutB    = pair.b;
  assign EraseA  = pair.erase_a;
  assign EraseB  = pair.erase_b;
  assign OutLast = pair.last;

`ifdef DEPUNCTURER_STATS_EN
  logic [15:0] erase_count;
  logic [1:0]  erase_inc;
  logic [16:0] erase_sum;

  assign erase_inc = {1'b0, next_pair.erase_a} + {1'b0, next_pair.erase_b};
  assign erase_sum = {1'b0, erase_count} + {15'd0, erase_inc};

  // Saturating per-frame erasure counter, cleared when a frame starts.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      erase_count <= 16'd0;
    end else if (frame_start) begin
      erase_count <= 16'd0;
    end else if (load) begin
      erase_count <= erase_sum[16] ? 16'hFFFF : erase_sum[15:0];
    end
  end

  assign EraseCount = erase_count;
`endif

endmodule

// File: tb/tb_viterbi_depuncturer.sv
// Self-checking bench for viterbi_depuncturer: directed frames from the test
// plan plus randomized frames, compared against a slot-sequence model.
module tb_viterbi_depuncturer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  Rate;
  logic        InValid;
  logic        InBit;
  logic        InLast;
  logic        InReady;
  logic        OutValid;
  logic        OutA;
  logic        OutB;
  logic        EraseA;
  logic        EraseB;
  logic        OutLast;
  logic        OutReady;
`ifdef DEPUNCTURER_STATS_EN
  logic [15:0] EraseCount;
`endif

  int checks   = 0;
  int failures = 0;
  int or_mode  = 0;   // 0: always ready, 1: random, 2: held low

  viterbi_depuncturer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Rate     (Rate),
    .InValid  (InValid),
    .InBit    (InBit),
    .InLast   (InLast),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutA     (OutA),
    .OutB     (OutB),
    .EraseA   (EraseA),
    .EraseB   (EraseB),
    .OutLast  (OutLast),
    .OutReady (OutReady)
`ifdef DEPUNCTURER_STATS_EN
    ,
    .EraseCount (EraseCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Pair monitor: records every transfer, sampled mid-cycle.
  logic [4:0] got_arr [0:1023];
  int         got_n = 0;
  always @(negedge Clock) begin
    if (!Reset && OutValid && OutReady) begin
      got_arr[got_n % 1024] <= {OutA, OutB, EraseA, EraseB, OutLast};
      got_n <= got_n + 1;
    end
  end

  // Reference data for the frame under test.
  bit         frame_bits [0:63];
  logic [4:0] exp_arr [0:63];
  int         exp_n;
  int         exp_erasures;
  int         stall [0:63];
  int         base;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    case (or_mode)
      0:       OutReady = 1'b1;
      1:       OutReady = ($urandom_range(0, 2) != 0);
      default: OutReady = 1'b0;
    endcase
  endtask

  // Present one bit and wait (bounded) until it is accepted.
  task automatic drive_bit(input bit b, input bit last, output int waits);
    int budget;
    waits   = 0;
    budget  = 0;
    InValid = 1'b1;
    InBit   = b;
    InLast  = last;
    @(negedge Clock);
    while (!InReady && budget < 100) begin
      tick();
      @(negedge Clock);
      waits++;
      budget++;
    end
    if (!InReady) check("accept_timeout", InReady, 1);
    tick();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  // Slot positions the transmitter removed, from the 802.11a pattern.
  function automatic bit is_stolen(input int r, input int p);
    if (r == 1) return (p % 4) == 3;
    if (r == 2) return ((p % 6) == 3) || ((p % 6) == 4);
    return 1'b0;
  endfunction

  // Expected pair list: lay the bits into mother-code slots, filling stolen
  // positions with erasures, pad an odd count with one erasure, pair them up.
  task automatic build_model(input int rate, input int n);
    bit vals[$];
    bit ers[$];
    int r;
    int p;
    r = (rate == 3) ? 0 : rate;
    p = 0;
    for (int i = 0; i < n; i++) begin
      while (is_stolen(r, p)) begin
        vals.push_back(1'b0);
        ers.push_back(1'b1);
        p++;
      end
      vals.push_back(frame_bits[i]);
      ers.push_back(1'b0);
      p++;
    end
    if (vals.size() % 2 == 1) begin
      vals.push_back(1'b0);
      ers.push_back(1'b1);
    end
    exp_n = vals.size() / 2;
    exp_erasures = 0;
    foreach (ers[k]) exp_erasures += int'(ers[k]);
    for (int k = 0; k < exp_n; k++)
      exp_arr[k] = {vals[2*k], vals[2*k+1], ers[2*k], ers[2*k+1], (k == exp_n - 1)};
  endtask

  // Wait for the frame's pairs and compare them with the model.
  task automatic finish_frame(input string name);
    int budget;
    budget = 0;
    while ((got_n - base) < exp_n && budget < 300) begin
      tick();
      budget++;
    end
    tick();
    tick();
    check({name, "_pair_count"}, got_n - base, exp_n);
    for (int k = 0; k < exp_n; k++)
      check($sformatf("%s_pair%0d", name, k), {27'd0, got_arr[(base + k) % 1024]}, {27'd0, exp_arr[k]});
`ifdef DEPUNCTURER_STATS_EN
    check({name, "_erase_count"}, {16'd0, EraseCount}, exp_erasures);
`endif
  endtask

  task automatic run_frame(input string name, input int rate, input int n,
                           input bit gaps, input bit chg);
    int w;
    build_model(rate, n);
    Rate = rate[1:0];
    base = got_n;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      drive_bit(frame_bits[i], (i == n - 1), w);
      stall[i] = w;
      if (i == 0 && chg) Rate = 2'($urandom_range(0, 3));
    end
    finish_frame(name);
  endtask

  initial begin
    int w;
    Reset    = 1'b1;
    Rate     = 2'b00;
    InValid  = 1'b0;
    InBit    = 1'b0;
    InLast   = 1'b0;
    OutReady = 1'b1;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", {OutValid, OutA, OutB, EraseA, EraseB, OutLast, InReady}, 7'd0);
`ifdef DEPUNCTURER_STATS_EN
    check("reset_erase_count", EraseCount, 16'd0);
`endif
    Reset = 1'b0;
    #1;
    check("idle_ready", InReady, 1);

    // Rate 1/2, 1,0,1,1: also check the first pair is visible one edge after B
    frame_bits[0] = 1; frame_bits[1] = 0; frame_bits[2] = 1; frame_bits[3] = 1;
    build_model(0, 4);
    Rate = 2'b00;
    base = got_n;
    drive_bit(1, 0, w);
    drive_bit(0, 0, w);
    check("r12_latency_valid", OutValid, 1);
    check("r12_latency_pair", {OutA, OutB, EraseA, EraseB}, 4'b1000);
    drive_bit(1, 0, w);
    drive_bit(1, 1, w);
    finish_frame("r12");

    // Rate 3/4, 1,0,1,1: two stolen slots before the last bit
    run_frame("r34", 2, 4, 0, 0);
    check("r34_p0", got_arr[base % 1024], 5'b10000);
    check("r34_p1", got_arr[(base + 1) % 1024], 5'b10010);
    check("r34_p2", got_arr[(base + 2) % 1024], 5'b01101);
    check("r34_stall", stall[3], 2);
`ifdef DEPUNCTURER_STATS_EN
    check("r34_erase_const", EraseCount, 16'd2);
`endif

    // Rate 2/3, 1,1,0: ends on an A slot
    frame_bits[0] = 1; frame_bits[1] = 1; frame_bits[2] = 0;
    run_frame("r23", 1, 3, 0, 0);
    check("r23_p1", got_arr[(base + 1) % 1024], 5'b00011);

    // Rate 2/3 longer frame: exactly one stall cycle at slot 3
    for (int i = 0; i < 6; i++) frame_bits[i] = i[0];
    run_frame("r23_long", 1, 6, 0, 0);
    check("r23_stall_slot3", stall[3], 1);
    check("r23_no_stall", stall[1] + stall[2] + stall[4], 0);

    // Rate 1/2, 3 bits: padded final pair
    frame_bits[0] = 0; frame_bits[1] = 1; frame_bits[2] = 1;
    run_frame("r12_pad", 0, 3, 0, 0);
    check("r12_pad_p1", got_arr[(base + 1) % 1024], 5'b10011);

    // Backpressure: OutReady low for 5 cycles with a B bit waiting
    for (int i = 0; i < 8; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    build_model(0, 8);
    Rate = 2'b00;
    base = got_n;
    drive_bit(frame_bits[0], 0, w);
    or_mode  = 2;
    OutReady = 1'b0;
    drive_bit(frame_bits[1], 0, w);
    drive_bit(frame_bits[2], 0, w);
    InValid = 1'b1;
    InBit   = frame_bits[3];
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      check($sformatf("bp_ready_low%0d", c), InReady, 0);
      tick();
    end
    or_mode  = 0;
    OutReady = 1'b1;
    for (int i = 3; i < 8; i++) drive_bit(frame_bits[i], (i == 7), w);
    finish_frame("bp");

    // Reset mid-frame at rate 3/4, then a clean rate 1/2 frame
    Rate = 2'b10;
    drive_bit(1, 0, w);
    or_mode  = 2;
    OutReady = 1'b0;
    drive_bit(1, 0, w);
    drive_bit(0, 0, w);
    Reset = 1'b1;
    #1;
    check("midreset_outputs", {OutValid, OutA, OutB, EraseA, EraseB, OutLast, InReady}, 7'd0);
    or_mode = 0;
    tick();
    tick();
    check("midreset_held", {OutValid, InReady}, 2'd0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) frame_bits[i] = 1'($urandom_range(0, 1));
    run_frame("post_reset", 0, 4, 0, 0);

    // Randomized frames: rate, length, gaps, backpressure, mid-frame rate changes
    or_mode = 1;
    for (int f = 0; f < 25; f++) begin
      int n;
      int r;
      n = $urandom_range(1, 20);
      r = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) frame_bits[i] = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d_r%0d", f, r), r, n, 1, 1);
    end
    or_mode = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
